// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences the shared memory,
// ALU and register file, and drives every datapath enable and mux select.
module multicycle_controller (
    input  logic       i_clk,
    input  logic       i_srst,
    input  logic [6:0] i_operand,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7bit5,
    input  logic       i_zeroFlag,
    output logic       o_pcWriteEn,
    output logic       o_adrSrc,
    output logic       o_irWriteEn,
    output logic       o_memWriteEn,
    output logic       o_regWriteEn,
    output logic [1:0] o_resultSrc,
    output logic [1:0] o_aluSrcA,
    output logic [1:0] o_aluSrcB,
    output logic [3:0] o_aluLogicOperation,
    output logic [3:0] o_state,
    output logic       o_illegalInstr
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;

    state_t     state_q, state_d;
    logic [3:0] alu_dec;

    always_ff @(posedge i_clk) begin
        state_q <= state_d;
    end

    // SUB only for register-register ops; immediate ops have no subtract form.
    always_comb begin
        unique case (i_funct3)
            3'b000:  alu_dec = (state_q == S_EXECUTER && i_funct7bit5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b100:  alu_dec = ALU_XOR;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d             = S_FETCH;
        o_pcWriteEn         = 1'b0;
        o_adrSrc            = 1'b0;
        o_irWriteEn         = 1'b0;
        o_memWriteEn        = 1'b0;
        o_regWriteEn        = 1'b0;
        o_resultSrc         = 2'b00;
        o_aluSrcA           = 2'b00;
        o_aluSrcB           = 2'b00;
        o_aluLogicOperation = ALU_ADD;
        o_illegalInstr      = 1'b0;
        case (state_q)
            S_FETCH: begin
                o_irWriteEn = 1'b1;
                o_pcWriteEn = 1'b1;
                o_aluSrcB   = 2'b10;
                o_resultSrc = 2'b10;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                o_aluSrcA = 2'b01;
                o_aluSrcB = 2'b01;
                case (i_operand)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      o_illegalInstr = 1'b1;
                endcase
            end
            S_MEMADR: begin
                o_aluSrcA = 2'b10;
                o_aluSrcB = 2'b01;
                state_d   = (i_operand == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                o_adrSrc = 1'b1;
                state_d  = S_MEMWB;
            end
            S_MEMWB: begin
                o_resultSrc  = 2'b01;
                o_regWriteEn = 1'b1;
            end
            S_MEMWRITE: begin
                o_adrSrc     = 1'b1;
                o_memWriteEn = 1'b1;
            end
            S_EXECUTER: begin
                o_aluSrcA           = 2'b10;
                o_aluLogicOperation = alu_dec;
                state_d             = S_ALUWB;
            end
            S_EXECUTEI: begin
                o_aluSrcA           = 2'b10;
                o_aluSrcB           = 2'b01;
                o_aluLogicOperation = alu_dec;
                state_d             = S_ALUWB;
            end
            S_ALUWB: begin
                o_regWriteEn = 1'b1;
            end
            S_BEQ: begin
                o_aluSrcA           = 2'b10;
                o_aluLogicOperation = ALU_SUB;
                o_pcWriteEn         = i_zeroFlag;
            end
            S_JAL: begin
                o_aluSrcA   = 2'b01;
                o_aluSrcB   = 2'b10;
                o_pcWriteEn = 1'b1;
                state_d     = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset wins over everything so an aborted instruction can never write.
        if (i_srst) begin
            state_d        = S_FETCH;
            o_pcWriteEn    = 1'b0;
            o_irWriteEn    = 1'b0;
            o_memWriteEn   = 1'b0;
            o_regWriteEn   = 1'b0;
            o_illegalInstr = 1'b0;
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed instruction table,
// reset-abort sequence and random instructions against a per-instruction model.
module tb_multicycle_controller;

    logic       i_clk = 1'b0;
    logic       i_srst;
    logic [6:0] i_operand;
    logic [2:0] i_funct3;
    logic       i_funct7bit5;
    logic       i_zeroFlag;
    logic       o_pcWriteEn, o_adrSrc, o_irWriteEn, o_memWriteEn, o_regWriteEn;
    logic [1:0] o_resultSrc, o_aluSrcA, o_aluSrcB;
    logic [3:0] o_aluLogicOperation, o_state;
    logic       o_illegalInstr;

    multicycle_controller dut (
        .i_clk(i_clk), .i_srst(i_srst), .i_operand(i_operand), .i_funct3(i_funct3),
        .i_funct7bit5(i_funct7bit5), .i_zeroFlag(i_zeroFlag),
        .o_pcWriteEn(o_pcWriteEn), .o_adrSrc(o_adrSrc), .o_irWriteEn(o_irWriteEn),
        .o_memWriteEn(o_memWriteEn), .o_regWriteEn(o_regWriteEn), .o_resultSrc(o_resultSrc),
        .o_aluSrcA(o_aluSrcA), .o_aluSrcB(o_aluSrcB), .o_aluLogicOperation(o_aluLogicOperation),
        .o_state(o_state), .o_illegalInstr(o_illegalInstr)
    );

    // clock / reset
    always #5 i_clk = ~i_clk;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // {pcw, adr, irw, memw, regw, res[2], srcA[2], srcB[2], alu[4], state[4], ill}
    logic [19:0] dut_vec;
    assign dut_vec = {o_pcWriteEn, o_adrSrc, o_irWriteEn, o_memWriteEn, o_regWriteEn,
                      o_resultSrc, o_aluSrcA, o_aluSrcB, o_aluLogicOperation, o_state,
                      o_illegalInstr};

    logic [19:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic is_r, input logic f7);
        case (f3)
            3'b000:  return (is_r && f7) ? 4'd1 : 4'd0;
            3'b010:  return 4'd5;
            3'b100:  return 4'd4;
            3'b110:  return 4'd3;
            3'b111:  return 4'd2;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic legal(input logic [6:0] op);
        return op == OP_LW || op == OP_SW || op == OP_R || op == OP_I || op == OP_BEQ || op == OP_JAL;
    endfunction

    // Expected output bundle for one cycle spent in state st.
    function automatic logic [19:0] outs(input int st, input logic [6:0] op, input logic [2:0] f3,
                                         input logic f7, input logic z);
        logic pcw = 0, adr = 0, irw = 0, memw = 0, regw = 0, ill = 0;
        logic [1:0] res = 0, sa = 0, sb = 0;
        logic [3:0] alu = 0;
        case (st)
            0:  begin pcw = 1; irw = 1; res = 2'b10; sb = 2'b10; end
            1:  begin sa = 2'b01; sb = 2'b01; ill = !legal(op); end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  adr = 1;
            4:  begin res = 2'b01; regw = 1; end
            5:  begin adr = 1; memw = 1; end
            6:  begin sa = 2'b10; alu = alu_ref(f3, 1'b1, f7); end
            7:  begin sa = 2'b10; sb = 2'b01; alu = alu_ref(f3, 1'b0, f7); end
            8:  regw = 1;
            9:  begin sa = 2'b10; alu = 4'd1; pcw = z; end
            10: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {pcw, adr, irw, memw, regw, res, sa, sb, alu, 4'(st), ill};
    endfunction

    // Reference: the state walk of each instruction class, then per-state outputs.
    task automatic build_model(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        int seq[$];
        exp_q.delete();
        seq.push_back(0);
        seq.push_back(1);
        case (op)
            OP_LW:  begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
            OP_SW:  begin seq.push_back(2); seq.push_back(5); end
            OP_R:   begin seq.push_back(6); seq.push_back(8); end
            OP_I:   begin seq.push_back(7); seq.push_back(8); end
            OP_BEQ: seq.push_back(9);
            OP_JAL: begin seq.push_back(10); seq.push_back(8); end
            default: ;
        endcase
        foreach (seq[i]) exp_q.push_back(outs(seq[i], op, f3, f7, z));
    endtask

    // Driver: entered just after a negedge with the DUT in FETCH; leaves in the next FETCH.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z,
                             output int cycles, output int regw_n, output int memw_n,
                             output int pcw_n, output logic [3:0] exec_alu);
        i_operand = op; i_funct3 = f3; i_funct7bit5 = f7; i_zeroFlag = z;
        build_model(op, f3, f7, z);
        cycles = 0; regw_n = 0; memw_n = 0; pcw_n = 0; exec_alu = 4'hF;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin
                @(negedge i_clk);
                #1;
                if (o_state == 4'd0) break;
            end
            cycles++;
            regw_n += int'(o_regWriteEn);
            memw_n += int'(o_memWriteEn);
            pcw_n  += int'(o_pcWriteEn);
            if (o_state == 4'd6 || o_state == 4'd7) exec_alu = o_aluLogicOperation;
            if (exp_q.size() > 0) check("cycle_outputs", dut_vec, exp_q.pop_front());
            else check("instr_overrun", dut_vec, 20'h0);
        end
        if (exp_q.size() != 0) check_int("instr_early_end", 0, exp_q.size());
    endtask

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         lat;
        int         regw;
        int         memw;
        int         pcw;
        logic       chk_alu;
        logic [3:0] alu;
    } vec_t;

    vec_t vt[11];

    initial begin
        int cyc, rn, mn, pn;
        logic [3:0] ea;
        int unsigned r;
        logic [6:0] rop;

        vt[0]  = '{OP_LW,  3'b010, 1'b0, 1'b0, 5, 1, 0, 1, 1'b0, 4'd0};
        vt[1]  = '{OP_SW,  3'b010, 1'b0, 1'b0, 4, 0, 1, 1, 1'b0, 4'd0};
        vt[2]  = '{OP_R,   3'b000, 1'b1, 1'b0, 4, 1, 0, 1, 1'b1, 4'd1};
        vt[3]  = '{OP_I,   3'b000, 1'b1, 1'b0, 4, 1, 0, 1, 1'b1, 4'd0};
        vt[4]  = '{OP_R,   3'b010, 1'b0, 1'b0, 4, 1, 0, 1, 1'b1, 4'd5};
        vt[5]  = '{OP_I,   3'b111, 1'b0, 1'b1, 4, 1, 0, 1, 1'b1, 4'd2};
        vt[6]  = '{OP_R,   3'b110, 1'b1, 1'b0, 4, 1, 0, 1, 1'b1, 4'd3};
        vt[7]  = '{OP_BEQ, 3'b000, 1'b0, 1'b1, 3, 0, 0, 2, 1'b0, 4'd0};
        vt[8]  = '{OP_BEQ, 3'b000, 1'b0, 1'b0, 3, 0, 0, 1, 1'b0, 4'd0};
        vt[9]  = '{OP_JAL, 3'b000, 1'b0, 1'b0, 4, 1, 0, 2, 1'b0, 4'd0};
        vt[10] = '{7'b1111111, 3'b000, 1'b0, 1'b0, 2, 0, 0, 1, 1'b0, 4'd0};

        i_srst = 1'b1; i_operand = OP_LW; i_funct3 = 3'b000; i_funct7bit5 = 1'b0; i_zeroFlag = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        #1;
        check("reset_state", {o_pcWriteEn, o_irWriteEn, o_memWriteEn, o_regWriteEn, o_illegalInstr, o_state},
              9'h0);
        @(negedge i_clk);
        i_srst = 1'b0;
        #1;
        check("post_reset_fetch", dut_vec, outs(0, OP_LW, 3'b000, 1'b0, 1'b0));

        foreach (vt[i]) begin
            run_instr(vt[i].op, vt[i].f3, vt[i].f7, vt[i].z, cyc, rn, mn, pn, ea);
            check_int($sformatf("latency_v%0d", i), cyc, vt[i].lat);
            check_int($sformatf("regw_pulses_v%0d", i), rn, vt[i].regw);
            check_int($sformatf("memw_pulses_v%0d", i), mn, vt[i].memw);
            check_int($sformatf("pcw_pulses_v%0d", i), pn, vt[i].pcw);
            if (vt[i].chk_alu) check_int($sformatf("exec_alu_v%0d", i), int'(ea), int'(vt[i].alu));
        end

        // Reset held three cycles in the middle of a load's MEMREAD.
        i_operand = OP_LW; i_funct3 = 3'b010; i_funct7bit5 = 1'b0; i_zeroFlag = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        check("reached_memread", {16'h0, o_state}, 20'h3);
        i_srst = 1'b1;
        #1;
        check("abort_enables_low", {15'h0, o_pcWriteEn, o_irWriteEn, o_memWriteEn, o_regWriteEn, o_illegalInstr},
              20'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            #1;
            check("in_reset", {o_pcWriteEn, o_irWriteEn, o_memWriteEn, o_regWriteEn, o_illegalInstr, o_state},
                  9'h0);
        end
        i_srst = 1'b0;
        #1;
        check("fetch_after_abort", dut_vec, outs(0, OP_LW, 3'b010, 1'b0, 1'b0));
        @(negedge i_clk);
        #1;
        check("decode_after_abort", {16'h0, o_state}, 20'h1);
        // Finish that load cleanly so the random phase starts from FETCH.
        for (int k = 0; k < 4; k++) @(negedge i_clk);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 7);
            case (r)
                0: rop = OP_LW;
                1: rop = OP_SW;
                2: rop = OP_R;
                3: rop = OP_I;
                4: rop = OP_BEQ;
                5: rop = OP_JAL;
                default: begin r = $urandom; rop = r[6:0]; end
            endcase
            r = $urandom;
            run_instr(rop, r[2:0], r[3], r[4], cyc, rn, mn, pn, ea);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
